// File: rtl/add2_clip_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | add2_clip_sched_if : requester and result handshake bundle                |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface add2_clip_sched_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_in1;
  logic [NREQ*WIDTH-1:0] req_in2;
  logic [NREQ-1:0]       req_mask;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_sum;
  logic [IDW-1:0]        res_id;
  logic                  res_sat;
  logic                  busy;

  modport master (
    output req_valid, req_in1, req_in2, req_mask, res_ready,
    input  req_ready, res_valid, res_sum, res_id, res_sat, busy
  );

  modport slave (
    input  req_valid, req_in1, req_in2, req_mask, res_ready,
    output req_ready, res_valid, res_sum, res_id, res_sat, busy
  );
endinterface
`default_nettype wire

// File: rtl/add2_clip_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | add2_clip_sched : round-robin shared saturating adder with credit FIFO    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module add2_clip_sched #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  add2_clip_sched_if.slave   bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = IDW + 1 + WIDTH;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [NREQ-1:0]  elig;
  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic             issue;
  int               idx;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]    cred_q, cred_d;

  logic             s1_vld_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [IDW-1:0]   s1_id_q;

  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] sum_d;
  logic             sat_d;
  logic             s2_vld_q, s2_sat_q;
  logic [WIDTH-1:0] s2_sum_q;
  logic [IDW-1:0]   s2_id_q;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic [EW-1:0]    head;
  logic             fifo_nempty, pop;
  logic [WIDTH-1:0] hold_sum_q;
  logic [IDW-1:0]   hold_id_q;
  logic             hold_sat_q;

  assign elig = bus.req_valid & bus.req_mask;

  // First eligible requester at or after ptr, wrapping upward.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_found && elig[idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

  assign issue         = grant_found && (cred_q != '0) && !rst;
  assign bus.req_ready = issue ? (NREQ'(1) << grant_idx) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (issue) ptr_d = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
  end

  assign pop    = fifo_nempty && bus.res_ready;
  assign cred_d = cred_q - CW'(issue) + CW'(pop);

  // Overflow shows up as disagreement between the two top bits of the wide sum.
  always_comb begin
    wide  = {s1_a_q[WIDTH-1], s1_a_q} + {s1_b_q[WIDTH-1], s1_b_q};
    sum_d = wide[WIDTH-1:0];
    sat_d = 1'b0;
    if (wide[WIDTH] != wide[WIDTH-1]) begin
      sat_d = 1'b1;
      sum_d = wide[WIDTH] ? SMIN : SMAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      cred_q   <= CW'(DEPTH);
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_id_q  <= '0;
      s2_vld_q <= 1'b0;
      s2_sum_q <= '0;
      s2_sat_q <= 1'b0;
      s2_id_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      cred_q   <= cred_d;
      s1_vld_q <= issue;
      if (issue) begin
        s1_a_q  <= bus.req_in1[grant_idx*WIDTH +: WIDTH];
        s1_b_q  <= bus.req_in2[grant_idx*WIDTH +: WIDTH];
        s1_id_q <= grant_idx;
      end
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_sum_q <= sum_d;
        s2_sat_q <= sat_d;
        s2_id_q  <= s1_id_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s2_vld_q) mem[wr_q] <= {s2_id_q, s2_sat_q, s2_sum_q};
  end

  assign head        = mem[rd_q];
  assign fifo_nempty = (cnt_q != '0);

  // Credits guarantee a free slot for every push, so no full check is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      hold_sum_q <= '0;
      hold_id_q  <= '0;
      hold_sat_q <= 1'b0;
    end else begin
      if (s2_vld_q) wr_q <= wr_q + 1'b1;
      if (pop) begin
        rd_q       <= rd_q + 1'b1;
        hold_sum_q <= head[WIDTH-1:0];
        hold_sat_q <= head[WIDTH];
        hold_id_q  <= head[EW-1 -: IDW];
      end
      cnt_q <= cnt_q + CW'(s2_vld_q) - CW'(pop);
    end
  end

  assign bus.res_valid = fifo_nempty;
  assign bus.res_sum   = fifo_nempty ? head[WIDTH-1:0]   : hold_sum_q;
  assign bus.res_sat   = fifo_nempty ? head[WIDTH]       : hold_sat_q;
  assign bus.res_id    = fifo_nempty ? head[EW-1 -: IDW] : hold_id_q;
  assign bus.busy      = s1_vld_q | s2_vld_q | fifo_nempty;

endmodule
`default_nettype wire

// File: tb/tb_add2_clip_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_add2_clip_sched : directed self-checking bench for add2_clip_sched     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_add2_clip_sched;
  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  add2_clip_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) bus ();

  add2_clip_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic set_lane(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_in1[i*WIDTH +: WIDTH] = a;
    bus.req_in2[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_mask  = 4'hF;
    bus.res_ready = 1'b0;
    bus.req_in1   = '0;
    bus.req_in2   = '0;
    #2;
    n_vec++; if (bus.req_ready !== 4'h0) begin n_err++; $display("FAIL rst_ready: got %h want 0", bus.req_ready); end
    n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.res_valid); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.res_sum !== 16'h0 || bus.res_id !== 2'd0 || bus.res_sat !== 1'b0) begin
      n_err++; $display("FAIL rst_res: got %h/%0d/%b want 0/0/0", bus.res_sum, bus.res_id, bus.res_sat); end
    @(negedge clk);
    bus.req_valid = 4'h0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_lane(2, 16'h1000, 16'h0234);
    bus.req_valid = 4'b0100;
    #1;
    n_vec++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL single_grant: got %b want 0100", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'h0;
    #1;
    n_vec++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL single_t1: got valid %b busy %b want 0 1", bus.res_valid, bus.busy); end
    @(negedge clk); #1;
    n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL single_t2: got valid %b want 0", bus.res_valid); end
    @(negedge clk); #1;
    n_vec++; if (bus.res_valid !== 1'b1 || bus.res_sum !== 16'h1234 || bus.res_id !== 2'd2 || bus.res_sat !== 1'b0) begin
      n_err++; $display("FAIL single_res: got v%b %h id%0d sat%b want v1 1234 id2 sat0",
                        bus.res_valid, bus.res_sum, bus.res_id, bus.res_sat); end
    bus.res_ready = 1'b1;
    @(negedge clk); #1;
    n_vec++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.res_sum !== 16'h1234) begin
      n_err++; $display("FAIL single_pop: got v%b busy%b sum %h want v0 busy0 1234", bus.res_valid, bus.busy, bus.res_sum); end
    bus.res_ready = 1'b0;
  endtask

  task automatic test_saturation();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [15:0] vs [4];
    logic        vt [4];
    va = '{16'h7000, 16'h8000, 16'h7FFF, 16'hFFFF};
    vb = '{16'h2000, 16'hFFFF, 16'h0000, 16'h0001};
    vs = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000};
    vt = '{1'b1, 1'b1, 1'b0, 1'b0};
    bus.res_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      set_lane(1, va[j], vb[j]);
      bus.req_valid = 4'b0010;
      #1;
      n_vec++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL sat_grant%0d: got %b want 0010", j, bus.req_ready); end
    end
    @(negedge clk); #1;
    n_vec++; if (bus.req_ready !== 4'h0) begin n_err++; $display("FAIL sat_nocredit: got %b want 0000", bus.req_ready); end
    bus.req_valid = 4'h0;
    @(negedge clk);
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      #1;
      n_vec++; if (bus.res_valid !== 1'b1 || bus.res_sum !== vs[j] || bus.res_sat !== vt[j] || bus.res_id !== 2'd1) begin
        n_err++; $display("FAIL sat_res%0d: got v%b %h sat%b id%0d want v1 %h sat%b id1",
                          j, bus.res_valid, bus.res_sum, bus.res_sat, bus.res_id, vs[j], vt[j]); end
      bus.res_ready = 1'b1;
      @(negedge clk);
    end
    #1;
    n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL sat_drain: got %b want 0", bus.res_valid); end
    bus.res_ready = 1'b0;
  endtask

  // Also covers pop+issue at credits = 1: three issues precede the first pop.
  task automatic test_round_robin();
    int exp_g [12];
    exp_g = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 3, 1, 3};
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_lane(i, 16'(i), 16'h0010);
    bus.res_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      bus.req_valid = (k < 12) ? 4'hF : 4'h0;
      bus.req_mask  = (k < 8) ? 4'hF : 4'b1010;
      #1;
      if (k < 12) begin
        n_vec++; if (bus.req_ready !== (4'b0001 << exp_g[k])) begin
          n_err++; $display("FAIL rr_grant%0d: got %b want id %0d", k, bus.req_ready, exp_g[k]); end
      end
      if (k >= 3) begin
        n_vec++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(exp_g[k-3]) || bus.res_sum !== 16'(16 + exp_g[k-3])) begin
          n_err++; $display("FAIL rr_res%0d: got v%b id%0d sum %h want v1 id%0d", k, bus.res_valid, bus.res_id,
                            bus.res_sum, exp_g[k-3]); end
      end
    end
    @(negedge clk); #1;
    n_vec++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL rr_idle: got v%b busy%b want 0 0", bus.res_valid, bus.busy); end
    bus.req_mask = 4'hF;
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_r [6];
    int         exp_d [4];
    exp_r = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    exp_d = '{1, 2, 3, 0};
    bus.res_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.req_valid = 4'hF;
      #1;
      n_vec++; if (bus.req_ready !== exp_r[k]) begin n_err++; $display("FAIL bp_grant%0d: got %b want %b", k, bus.req_ready, exp_r[k]); end
    end
    @(negedge clk); #1;
    n_vec++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0) begin
      n_err++; $display("FAIL bp_head: got v%b id%0d want v1 id0", bus.res_valid, bus.res_id); end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_reissue: got %b want 0001", bus.req_ready); end
    @(negedge clk); #1;
    n_vec++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_reblock: got %b want 0000", bus.req_ready); end
    bus.req_valid = 4'h0;
    bus.res_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) begin @(negedge clk); #1; end
      n_vec++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(exp_d[j]) || bus.res_sum !== 16'(16 + exp_d[j])) begin
        n_err++; $display("FAIL bp_drain%0d: got v%b id%0d sum %h want v1 id%0d", j, bus.res_valid, bus.res_id,
                          bus.res_sum, exp_d[j]); end
    end
    @(negedge clk); #1;
    n_vec++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL bp_idle: got v%b busy%b want 0 0", bus.res_valid, bus.busy); end
    bus.res_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_r [5];
    exp_r = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    bus.res_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.req_valid = (k < 3) ? 4'hF : 4'h0;
    end
    bus.req_valid = 4'hF;
    #1;
    n_vec++; if (bus.res_valid !== 1'b1 || bus.busy !== 1'b1 || bus.req_ready !== 4'b0001) begin
      n_err++; $display("FAIL ar_pre: got v%b busy%b rdy %b want 1 1 0001", bus.res_valid, bus.busy, bus.req_ready); end
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 4'h0) begin
      n_err++; $display("FAIL ar_async: got v%b busy%b rdy %b want 0 0 0000", bus.res_valid, bus.busy, bus.req_ready); end
    n_vec++; if (bus.res_sum !== 16'h0 || bus.res_id !== 2'd0) begin
      n_err++; $display("FAIL ar_hold: got %h id%0d want 0000 id0", bus.res_sum, bus.res_id); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_vec++; if (bus.req_ready !== exp_r[k]) begin n_err++; $display("FAIL ar_credit%0d: got %b want %b", k, bus.req_ready, exp_r[k]); end
    end
    bus.req_valid = 4'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_round_robin();
    test_backpressure();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
